// File: rtl/audio_clkgen.sv
// audio_clkgen
//   Lock-qualified audio clock generator running entirely on refclk.
//   pll_locked is synchronised, then qualified by LOCK_HOLD consecutive
//   locked cycles. Once run is high, a programmable divider generates bclk,
//   and per-fall counters generate lrclk / frame sync and slot/bit indices.
//   Strobes are refclk-domain enables that coincide with the bclk edge they
//   mark.
//
// Ports
//   refclk        in   master clock, sole clock
//   rst           in   asynchronous active-low reset
//   pll_locked    in   PLL locked flag (asynchronous to refclk)
//   bclk_div      in   bclk half-period minus 1, in refclk cycles
//   run           out  clocks valid
//   bclk          out  bit clock, period 2*(div_act+1) refclk cycles
//   lrclk         out  LR clock (FS_MODE 0) or one-bclk frame sync (FS_MODE 1)
//   bclk_rise_en  out  strobe in the cycle bclk becomes 1
//   bclk_fall_en  out  strobe in the cycle bclk becomes 0
//   bit_idx       out  bit within slot, 0 = MSB
//   slot_idx      out  slot within frame
//   frame_start   out  strobe with bclk_fall_en when indices wrap to 0,0
//   frame_cnt     out  frames since run rose (only with CLKGEN_FRAME_CNT_EN)
//
// Configuration macro: CLKGEN_FRAME_CNT_EN adds the frame_cnt port/register.

module audio_clkgen #(
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned NUM_SLOTS   = 2,
  parameter int unsigned FS_MODE     = 0,
  parameter int unsigned BCLK_DIV_W  = 8,
  parameter int unsigned LOCK_HOLD   = 1024,
  parameter int unsigned FRAME_CNT_W = 32,
  localparam int unsigned BIT_W      = $clog2(SLOT_BITS),
  localparam int unsigned SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic [BCLK_DIV_W-1:0] bclk_div,
  output logic                  run,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  bclk_rise_en,
  output logic                  bclk_fall_en,
  output logic [BIT_W-1:0]      bit_idx,
  output logic [SLOT_W-1:0]     slot_idx,
  output logic                  frame_start
`ifdef CLKGEN_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned LOCK_W = $clog2(LOCK_HOLD + 1);

  if (SLOT_BITS < 2 || NUM_SLOTS < 1 || LOCK_HOLD < 1 || FRAME_CNT_W < 1 ||
      FS_MODE > 1 || (FS_MODE == 0 && (NUM_SLOTS % 2) != 0)) begin : g_param_check
    $error("audio_clkgen: illegal parameter combination");
  end

  logic                  lk_s1;
  logic                  lk_s;
  logic [LOCK_W-1:0]     lock_cnt;
  logic                  run_nxt;
  logic                  active;

  logic [BCLK_DIV_W-1:0] div_cnt;
  logic [BCLK_DIV_W-1:0] div_act;

  logic                  div_wrap;
  logic                  rise_c;
  logic                  fall_c;
  logic                  bit_last;
  logic                  slot_last;
  logic [BIT_W-1:0]      bit_inc;
  logic [SLOT_W-1:0]     slot_inc;
  logic                  fs_c;
  logic                  lr_c;

  // ---------------------------------------------------------------------
  // Lock qualification
  // ---------------------------------------------------------------------
  assign run_nxt = lk_s && (lock_cnt == LOCK_W'(LOCK_HOLD));

  // The clock machinery advances only when run was already high and stays
  // high; on the rising cycle it still holds its idle state, so the first
  // bclk toggle lands div_act+1 cycles after run rises, and on a lock drop
  // everything clears on the same edge as run.
  assign active = run && run_nxt;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lk_s1    <= 1'b0;
      lk_s     <= 1'b0;
      lock_cnt <= '0;
      run      <= 1'b0;
    end else begin
      lk_s1 <= pll_locked;
      lk_s  <= lk_s1;
      if (!lk_s) begin
        lock_cnt <= '0;
      end else if (lock_cnt != LOCK_W'(LOCK_HOLD)) begin
        lock_cnt <= lock_cnt + LOCK_W'(1);
      end
      run <= run_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Divider / index next-state
  // ---------------------------------------------------------------------
  always_comb begin
    div_wrap  = (div_cnt == div_act);
    rise_c    = active && div_wrap && !bclk;
    fall_c    = active && div_wrap && bclk;
    bit_last  = (bit_idx == BIT_W'(SLOT_BITS - 1));
    slot_last = (slot_idx == SLOT_W'(NUM_SLOTS - 1));
    bit_inc   = bit_last ? '0 : bit_idx + BIT_W'(1);
    slot_inc  = slot_idx;
    if (bit_last) begin
      slot_inc = slot_last ? '0 : slot_idx + SLOT_W'(1);
    end
    fs_c = fall_c && bit_last && slot_last;
    if (FS_MODE == 0) begin
      lr_c = (slot_inc >= SLOT_W'(NUM_SLOTS / 2));
    end else begin
      lr_c = bit_last && slot_last;
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      div_cnt      <= '0;
      div_act      <= '0;
      bclk         <= 1'b0;
      lrclk        <= 1'b0;
      bclk_rise_en <= 1'b0;
      bclk_fall_en <= 1'b0;
      frame_start  <= 1'b0;
      bit_idx      <= '0;
      slot_idx     <= '0;
    end else if (!active) begin
      // Idle: indices parked on the last bit so the first fall wraps to 0,0.
      div_cnt      <= '0;
      div_act      <= bclk_div;
      bclk         <= 1'b0;
      lrclk        <= 1'b0;
      bclk_rise_en <= 1'b0;
      bclk_fall_en <= 1'b0;
      frame_start  <= 1'b0;
      bit_idx      <= BIT_W'(SLOT_BITS - 1);
      slot_idx     <= SLOT_W'(NUM_SLOTS - 1);
    end else begin
      bclk_rise_en <= rise_c;
      bclk_fall_en <= fall_c;
      frame_start  <= fs_c;
      if (div_wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + BCLK_DIV_W'(1);
      end
      if (fall_c) begin
        bit_idx  <= bit_inc;
        slot_idx <= slot_inc;
        lrclk    <= lr_c;
      end
      // Reload on the same edge the counter wraps into the new frame, so the
      // whole new frame (starting with its first half-period) uses it.
      if (fs_c) begin
        div_act <= bclk_div;
      end
    end
  end

`ifdef CLKGEN_FRAME_CNT_EN
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (!active) begin
      frame_cnt <= '0;
    end else if (fs_c) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_audio_clkgen.sv
// tb_audio_clkgen
//   Two instances (I2S-style 8x4 and TDM-style 5x3 with one-bclk sync) share
//   pll_locked and get independent random dividers. A timing-arithmetic
//   reference model predicts every cycle's outputs from the lock history
//   and the position within the current frame; predictions are queued at
//   each rising edge and popped/compared by a monitor on the falling edge.

module tb_audio_clkgen;

  typedef struct packed {
    logic run;
    logic bclk;
    logic lr;
    logic re;
    logic fe;
    logic fs;
    int   bi;
    int   si;
    int   fc;
  } exp_t;

  typedef struct packed {
    int   st0;     // locked-sample streak ending at this edge
    int   st1;     // ... one edge earlier
    int   st2;     // ... two edges earlier
    logic run;
    logic pre;     // between run rising and the first frame start
    int   p;       // cycles since the current segment anchor
    int   h;       // bclk half period of the current segment
    int   frames;
    exp_t e;
  } mdl_t;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll;
  logic [3:0] div0;
  logic [3:0] div1;

  logic       run0, bclk0, lr0, re0, fe0, fs0;
  logic [2:0] bi0;
  logic [1:0] si0;
  logic       run1, bclk1, lr1, re1, fe1, fs1;
  logic [2:0] bi1;
  logic [1:0] si1;
`ifdef CLKGEN_FRAME_CNT_EN
  logic [3:0] fc0;
  logic [3:0] fc1;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   exp_fs0 = 0, exp_fs1 = 0, act_fs0 = 0, act_fs1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  mdl_t m0, m1;

  always #5 refclk = ~refclk;

  audio_clkgen #(
    .SLOT_BITS  (8),
    .NUM_SLOTS  (4),
    .FS_MODE    (0),
    .BCLK_DIV_W (4),
    .LOCK_HOLD  (16),
    .FRAME_CNT_W(4)
  ) u0 (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll),
    .bclk_div    (div0),
    .run         (run0),
    .bclk        (bclk0),
    .lrclk       (lr0),
    .bclk_rise_en(re0),
    .bclk_fall_en(fe0),
    .bit_idx     (bi0),
    .slot_idx    (si0),
    .frame_start (fs0)
`ifdef CLKGEN_FRAME_CNT_EN
    ,
    .frame_cnt   (fc0)
`endif
  );

  audio_clkgen #(
    .SLOT_BITS  (5),
    .NUM_SLOTS  (3),
    .FS_MODE    (1),
    .BCLK_DIV_W (4),
    .LOCK_HOLD  (3),
    .FRAME_CNT_W(4)
  ) u1 (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll),
    .bclk_div    (div1),
    .run         (run1),
    .bclk        (bclk1),
    .lrclk       (lr1),
    .bclk_rise_en(re1),
    .bclk_fall_en(fe1),
    .bit_idx     (bi1),
    .slot_idx    (si1),
    .frame_start (fs1)
`ifdef CLKGEN_FRAME_CNT_EN
    ,
    .frame_cnt   (fc1)
`endif
  );

  // Reference model, advanced once per rising edge with the inputs sampled
  // at that edge. run is high once the last L+1 samples two edges back were
  // all locked; bclk/strobes/indices follow from the position p within the
  // current frame of 2*h*S*N cycles.
  function automatic mdl_t step(input mdl_t m, input logic rn, input logic s,
                                input int d, input int S, input int N,
                                input int fsm, input int L, input int FW);
    mdl_t n;
    logic nr;
    int   per;
    int   k;
    n = m;
    if (!rn) begin
      n = '0;
      return n;
    end
    n.st2 = m.st1;
    n.st1 = m.st0;
    n.st0 = s ? ((m.st0 > L) ? m.st0 : m.st0 + 1) : 0;
    nr = (n.st2 >= L + 1);
    if (!(nr && m.run)) begin
      n.pre    = 1'b1;
      n.p      = 0;
      n.h      = d + 1;
      n.frames = 0;
      n.e      = '0;
      n.e.run  = nr;
      n.e.bi   = S - 1;
      n.e.si   = N - 1;
    end else begin
      n.p = m.p + 1;
      per = 2 * n.h;
      if ((n.pre && n.p == per) || (!n.pre && n.p == per * S * N)) begin
        n.pre    = 1'b0;
        n.p      = 0;
        n.h      = d + 1;
        n.frames = (m.frames + 1) % (1 << FW);
      end
      per     = 2 * n.h;
      n.e     = '0;
      n.e.run = 1'b1;
      n.e.fc  = n.frames;
      if (n.pre) begin
        n.e.bclk = (n.p >= n.h);
        n.e.re   = (n.p == n.h);
        n.e.bi   = S - 1;
        n.e.si   = N - 1;
      end else begin
        k        = n.p / per;
        n.e.bclk = ((n.p % per) >= n.h);
        n.e.re   = ((n.p % per) == n.h);
        n.e.fe   = ((n.p % per) == 0);
        n.e.fs   = (n.p == 0);
        n.e.bi   = k % S;
        n.e.si   = k / S;
        n.e.lr   = (fsm != 0) ? (k == 0) : (n.e.si >= N / 2);
      end
    end
    n.run = nr;
    return n;
  endfunction

  task automatic check(input string name, input exp_t a, input exp_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got run=%0b bclk=%0b lr=%0b re=%0b fe=%0b fs=%0b bit=%0d slot=%0d fc=%0d want run=%0b bclk=%0b lr=%0b re=%0b fe=%0b fs=%0b bit=%0d slot=%0d fc=%0d",
               name, cyc, a.run, a.bclk, a.lr, a.re, a.fe, a.fs, a.bi, a.si, a.fc,
               e.run, e.bclk, e.lr, e.re, e.fe, e.fs, e.bi, e.si, e.fc);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, a, e);
    end
  endtask

  // Scoreboard producer: predictions pushed at each rising edge.
  initial begin
    m0 = '0;
    m1 = '0;
    forever begin
      @(posedge refclk);
      m0 = step(m0, rst, pll, int'(div0), 8, 4, 0, 16, 4);
      m1 = step(m1, rst, pll, int'(div1), 5, 3, 1, 3, 4);
      q0.push_back(m0.e);
      q1.push_back(m1.e);
      if (m0.e.fs) exp_fs0++;
      if (m1.e.fs) exp_fs1++;
      cyc++;
    end
  end

  // Monitor: outputs sampled on the falling edge, compared against the queue.
  initial begin
    exp_t a;
    exp_t e;
    forever begin
      @(negedge refclk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = '0;
        a.run = run0; a.bclk = bclk0; a.lr = lr0; a.re = re0; a.fe = fe0; a.fs = fs0;
        a.bi = int'(bi0); a.si = int'(si0);
`ifdef CLKGEN_FRAME_CNT_EN
        a.fc = int'(fc0);
`else
        a.fc = e.fc;
`endif
        if (fs0 === 1'b1) act_fs0++;
        check("u0", a, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = '0;
        a.run = run1; a.bclk = bclk1; a.lr = lr1; a.re = re1; a.fe = fe1; a.fs = fs1;
        a.bi = int'(bi1); a.si = int'(si1);
`ifdef CLKGEN_FRAME_CNT_EN
        a.fc = int'(fc1);
`else
        a.fc = e.fc;
`endif
        if (fs1 === 1'b1) act_fs1++;
        check("u1", a, e);
      end
    end
  end

  // Stimulus: lock episodes of random length separated by short drops
  // (some single-cycle glitches), with random mid-frame divider changes.
  initial begin
    int on_len;
    int off_len;
    rst  = 1'b0;
    pll  = 1'b0;
    div0 = 4'd15;
    div1 = 4'd15;
    repeat (4) @(posedge refclk);
    #2;
    rst = 1'b1;
    pll = 1'b1;
    for (int ep = 0; ep < 14; ep++) begin
      on_len = (ep == 0) ? 2600 : int'($urandom_range(4000, 1200));
      if (ep == 1) begin
        div0 = 4'd0;
        div1 = 4'd0;
      end else if (ep > 1) begin
        div0 = 4'($urandom);
        div1 = 4'($urandom);
      end
      for (int c = 0; c < on_len; c++) begin
        @(posedge refclk);
        #2;
        if (ep == 0 && c == 1000) begin
          div0 = 4'd7;
          div1 = 4'd7;
        end else if (ep > 1 && $urandom_range(149, 0) == 0) begin
          div0 = 4'($urandom);
          div1 = 4'($urandom);
        end
      end
      pll = 1'b0;
      off_len = (ep % 3 == 0) ? 1 : int'($urandom_range(12, 2));
      repeat (off_len) begin
        @(posedge refclk);
        #2;
      end
      pll = 1'b1;
    end
    repeat (3) @(negedge refclk);
    #1;
    check_int("queue0_drained", q0.size(), 0);
    check_int("queue1_drained", q1.size(), 0);
    check_int("frame_starts_u0", act_fs0, exp_fs0);
    check_int("frame_starts_u1", act_fs1, exp_fs1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
